sparc_ctrl_sequencer: RTL and testbench

Multicycle control unit that sequences the SPARC datapath through fetch, decode, execute, memory and writeback, one instruction at a time. Drives the datapath load enables and the RAM handshake (MOV out, MFC in). Sits beside DataPath and replaces its free-running behaviour. It waits for the post-precharge start pulse and stops on finish or on a fault.

---
 rtl/sparc_ctrl_sequencer_pkg.sv | 37 +++
 rtl/sparc_ctrl_sequencer_if.sv | 28 ++
 rtl/sparc_ctrl_sequencer_timer.sv | 29 ++
 rtl/sparc_ctrl_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sparc_ctrl_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparc_ctrl_sequencer_pkg.sv
// Shared encodings for the SPARC multicycle control sequencer: state codes,
// instruction field values and next-PC select codes.
package sparc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MADDR  = 4'd5,
    S_MWAIT  = 4'd6,
    S_WB     = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9,
    S_FAULT  = 4'd10
  } state_e;

  localparam logic [1:0] OP_BR    = 2'd0;
  localparam logic [1:0] OP_CALL  = 2'd1;
  localparam logic [1:0] OP_ARITH = 2'd2;
  localparam logic [1:0] OP_MEM   = 2'd3;

  localparam logic [2:0] OP2_BICC = 3'b010;
  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_ST   = 6'b000100;
  localparam logic [3:0] COND_BA  = 4'b1000;

  localparam logic [1:0] PC_SEL_NPC  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_CALL = 2'd2;

  function automatic logic bicc_taken(input logic [3:0] cond, input logic cond_true);
    return cond_true || (cond == COND_BA);
  endfunction

endpackage

// File: rtl/sparc_ctrl_sequencer_if.sv
// Control bundle between the sequencer, the datapath and the RAM.
// Handshake: mov (valid) rises with a request and holds, rw stable, until the cycle mfc (ready) is seen high.
interface sparc_ctrl_sequencer_if;
  logic [31:0] ir;
  logic        cond_true;
  logic        mfc;
  logic        mov;
  logic        rw;
  logic        mar_ld;
  logic        mdr_ld;
  logic        ir_ld;
  logic        pc_ld;
  logic        npc_ld;
  logic        rf_we;
  logic        cc_we;
  logic        mar_sel;
  logic [1:0]  pc_sel;

  modport master (
    input  ir, cond_true, mfc,
    output mov, rw, mar_ld, mdr_ld, ir_ld, pc_ld, npc_ld, rf_we, cc_we, mar_sel, pc_sel
  );

  modport slave (
    output ir, cond_true, mfc,
    input  mov, rw, mar_ld, mdr_ld, ir_ld, pc_ld, npc_ld, rf_we, cc_we, mar_sel, pc_sel
  );
endinterface

// File: rtl/sparc_ctrl_sequencer_timer.sv
// Memory-wait watchdog: counts wait cycles without mfc and flags the cycle
// whose increment would bring the count to MEM_TIMEOUT.
module sparc_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/sparc_ctrl_sequencer.sv
// Multicycle control sequencer for the SPARC datapath: walks fetch, decode,
// execute, memory and writeback for one instruction at a time.
module sparc_ctrl_sequencer
  import sparc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   finish,
  sparc_ctrl_sequencer_if.master bus,
  output logic                   busy,
  output logic                   fault,
  output logic [STATE_W-1:0]     state
);

  state_e     r_state, w_next;
  logic       r_mov, r_fault;
  logic [1:0] w_op;
  logic [2:0] w_op2;
  logic [5:0] w_op3;
  logic [3:0] w_cond;
  logic       w_is_ld, w_is_st, w_in_wait, w_expired, w_mfc_ok;
  logic       w_mar_ld, w_mdr_ld, w_ir_ld, w_pc_ld, w_npc_ld, w_rf_we, w_cc_we;
  logic       w_mar_sel, w_rw;
  logic [1:0] w_pc_sel;
  logic       w_unused_ir;

  assign w_op        = bus.ir[31:30];
  assign w_cond      = bus.ir[28:25];
  assign w_op2       = bus.ir[24:22];
  assign w_op3       = bus.ir[24:19];
  assign w_unused_ir = ^{bus.ir[29], bus.ir[18:0]};
  assign w_is_ld     = (w_op3 == OP3_LD);
  assign w_is_st     = (w_op3 == OP3_ST);
  assign w_in_wait   = (r_state == S_FWAIT) || (r_state == S_MWAIT);
  // finish outranks a completing mfc, so no completion-side enables fire then.
  assign w_mfc_ok    = bus.mfc && !finish;

  sparc_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   ((r_state == S_FETCH) || (r_state == S_MADDR)),
    .i_en      (w_in_wait && !bus.mfc),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_mar_ld  = 1'b0;
    w_mdr_ld  = 1'b0;
    w_ir_ld   = 1'b0;
    w_pc_ld   = 1'b0;
    w_npc_ld  = 1'b0;
    w_rf_we   = 1'b0;
    w_cc_we   = 1'b0;
    w_mar_sel = 1'b0;
    w_rw      = 1'b0;
    w_pc_sel  = PC_SEL_NPC;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH: begin
        w_mar_ld = 1'b1;
        w_next   = S_FWAIT;
      end
      S_FWAIT: begin
        w_rw = 1'b1;
        if (bus.mfc) begin
          w_ir_ld = w_mfc_ok;
          w_next  = S_DECODE;
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_ARITH: w_next = S_EXEC;
          OP_MEM:   w_next = (w_is_ld || w_is_st) ? S_MADDR : S_FAULT;
          OP_CALL:  w_next = S_BRANCH;
          default:  w_next = (w_op2 == OP2_BICC) ? S_BRANCH : S_FAULT;
        endcase
      end
      S_EXEC: begin
        w_rf_we  = 1'b1;
        w_cc_we  = w_op3[4];
        w_pc_ld  = 1'b1;
        w_npc_ld = 1'b1;
        w_next   = S_FETCH;
      end
      S_MADDR: begin
        w_mar_sel = 1'b1;
        w_mar_ld  = 1'b1;
        w_mdr_ld  = w_is_st;
        w_next    = S_MWAIT;
      end
      S_MWAIT: begin
        w_rw = !w_is_st;
        if (bus.mfc) begin
          if (w_is_st) begin
            w_pc_ld  = w_mfc_ok;
            w_npc_ld = w_mfc_ok;
            w_next   = S_FETCH;
          end else begin
            w_mdr_ld = w_mfc_ok;
            w_next   = S_WB;
          end
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_pc_ld  = 1'b1;
        w_npc_ld = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        w_pc_ld  = 1'b1;
        w_npc_ld = 1'b1;
        if (w_op == OP_CALL) begin
          w_pc_sel = PC_SEL_CALL;
          w_rf_we  = 1'b1;
        end else if (bicc_taken(w_cond, bus.cond_true)) begin
          w_pc_sel = PC_SEL_BR;
        end
        w_next = S_FETCH;
      end
      S_HALT:   w_next = S_HALT;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
    if (finish && (r_state != S_FAULT)) w_next = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mov   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mov   <= (w_next == S_FWAIT) || (w_next == S_MWAIT);
      if (w_next == S_FAULT) r_fault <= 1'b1;
    end
  end

  assign bus.mov     = r_mov;
  assign bus.rw      = w_rw;
  assign bus.mar_ld  = w_mar_ld;
  assign bus.mdr_ld  = w_mdr_ld;
  assign bus.ir_ld   = w_ir_ld;
  assign bus.pc_ld   = w_pc_ld;
  assign bus.npc_ld  = w_npc_ld;
  assign bus.rf_we   = w_rf_we;
  assign bus.cc_we   = w_cc_we;
  assign bus.mar_sel = w_mar_sel;
  assign bus.pc_sel  = w_pc_sel;

  assign busy  = !(r_state inside {S_IDLE, S_HALT, S_FAULT});
  assign fault = r_fault;
  assign state = STATE_W'(r_state);

endmodule

// File: tb/tb_sparc_ctrl_sequencer.sv
// Bench for sparc_ctrl_sequencer: directed instructions with a RAM responder,
// enable-pulse records checked against a scoreboard queue.
module tb_sparc_ctrl_sequencer;
  import sparc_ctrl_pkg::*;

  localparam int W = 16;
  localparam logic [6:0] EN_MAR = 7'b1000000;
  localparam logic [6:0] EN_MDR = 7'b0100000;
  localparam logic [6:0] EN_IR  = 7'b0010000;
  localparam logic [6:0] EN_PCN = 7'b0001100;
  localparam logic [6:0] EN_RF  = 7'b0000010;
  localparam logic [6:0] EN_CC  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n, start, finish, busy, fault;
  logic [3:0] state;
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc;
  logic [W-1:0] exp_q[$];

  sparc_ctrl_sequencer_if bus();

  sparc_ctrl_sequencer #(.MEM_TIMEOUT(16), .STATE_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .finish (finish),
    .bus    (bus),
    .busy   (busy),
    .fault  (fault),
    .state  (state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic mv, input logic r,
                                      input logic [6:0] en, input logic ms, input logic [1:0] ps);
    return {st, mv, r, en, ms, ps};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic start_seq();
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; bus.mfc = 1'b0;
    step(); step();
    rst_n = 1'b1;
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, PC_SEL_NPC));
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // RAM responder: mfc in the (k+1)th cycle of mov; optional finish alongside an MWAIT mfc.
  task automatic run_until(input string name, input logic [3:0] target, input int k_f,
                           input int k_m, input bit fin_on_mfc, input int budget, output int n);
    int mov_cnt;
    int kk;
    mov_cnt = 0;
    n = 0;
    while (n < budget) begin
      if (bus.mov) begin
        kk = (state == S_FWAIT) ? k_f : k_m;
        bus.mfc = (mov_cnt == kk);
        finish = fin_on_mfc && bus.mfc && (state == S_MWAIT);
        mov_cnt++;
      end else begin
        bus.mfc = 1'b0;
        mov_cnt = 0;
      end
      step();
      n++;
      finish = 1'b0;
      if (state == target) break;
    end
    bus.mfc = 1'b0;
    chk({name, "_reached"}, int'(state), int'(target));
  endtask

  task automatic run_instr(input string name, input logic [31:0] ir_v, input logic cond,
                           input int k, input int exp_lat);
    int n;
    chk({name, "_at_fetch"}, int'(state), int'(S_FETCH));
    bus.ir = ir_v;
    bus.cond_true = cond;
    run_until(name, S_FETCH, k, k, 1'b0, 80, n);
    chk({name, "_latency"}, n, exp_lat);
  endtask

  // scoreboard monitor: every cycle with a load-enable pulse must match the queue head
  logic [6:0]   obs_en;
  logic [W-1:0] obs, exp_v;
  initial forever begin
    @(negedge clk);
    obs_en = {bus.mar_ld, bus.mdr_ld, bus.ir_ld, bus.pc_ld, bus.npc_ld, bus.rf_we, bus.cc_we};
    obs = mk(state, bus.mov, bus.rw, obs_en, bus.mar_sel, bus.pc_sel);
    if ((|obs_en) === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got %h expected none", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL pulse_record: got %h expected %h", obs, exp_v);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0;
    bus.ir = 32'h0; bus.cond_true = 1'b0; bus.mfc = 1'b0;

    // reset and start
    step(); step();
    chk("reset_state", int'(state), 0);
    chk("reset_mov", int'(bus.mov), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_enables", int'({bus.mar_ld, bus.mdr_ld, bus.ir_ld, bus.pc_ld, bus.npc_ld,
                                bus.rf_we, bus.cc_we}), 0);
    rst_n = 1'b1;
    step();
    chk("idle_hold", int'(state), 0);
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, PC_SEL_NPC));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_fetch", int'(state), 1);
    chk("fetch_busy", int'(busy), 1);
    step();
    chk("fwait_state", int'(state), 2);
    chk("fwait_mov", int'(bus.mov), 1);
    chk("fwait_rw", int'(bus.rw), 1);
    rst_n = 1'b0;
    step();
    chk("reset_drops_mov", int'(bus.mov), 0);
    chk("reset_to_idle", int'(state), 0);

    // back-to-back instruction stream
    start_seq();
    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_EXEC, 0, 0, EN_RF | EN_PCN, 0, PC_SEL_NPC));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("add", 32'h82004002, 1'b0, 2, 6);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_EXEC, 0, 0, EN_RF | EN_PCN | EN_CC, 0, PC_SEL_NPC));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("addcc", 32'h82804002, 1'b0, 0, 4);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_MADDR, 0, 0, EN_MAR, 1, 0));
    push(mk(S_MWAIT, 1, 1, EN_MDR, 0, 0));
    push(mk(S_WB, 0, 0, EN_RF | EN_PCN, 0, PC_SEL_NPC));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("ld", 32'hC4006000, 1'b0, 1, 8);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_MADDR, 0, 0, EN_MAR | EN_MDR, 1, 0));
    push(mk(S_MWAIT, 1, 0, EN_PCN, 0, PC_SEL_NPC));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("st", 32'hC4206000, 1'b0, 0, 5);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_BRANCH, 0, 0, EN_PCN, 0, PC_SEL_BR));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("ba", 32'h10800004, 1'b0, 0, 4);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_BRANCH, 0, 0, EN_PCN, 0, PC_SEL_NPC));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("be_not_taken", 32'h02800004, 1'b0, 1, 5);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_BRANCH, 0, 0, EN_PCN, 0, PC_SEL_BR));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("be_taken", 32'h02800004, 1'b1, 0, 4);

    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_BRANCH, 0, 0, EN_RF | EN_PCN, 0, PC_SEL_CALL));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("call", 32'h40000003, 1'b0, 0, 4);

    // mfc on the last allowed wait cycle completes normally
    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_EXEC, 0, 0, EN_RF | EN_PCN, 0, PC_SEL_NPC));
    push(mk(S_FETCH, 0, 0, EN_MAR, 0, 0));
    run_instr("add_mfc_cycle16", 32'h82004002, 1'b0, 15, 19);

    // UNIMP faults and stays faulted through start pulses
    start_seq();
    bus.ir = 32'h00000000;
    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    run_until("unimp", S_FAULT, 0, 0, 1'b0, 20, cyc);
    chk("unimp_latency", cyc, 3);
    chk("unimp_fault", int'(fault), 1);
    chk("unimp_busy", int'(busy), 0);
    chk("unimp_mov", int'(bus.mov), 0);
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; step(); start = 1'b0; step();
    end
    chk("fault_absorbing", int'(state), int'(S_FAULT));
    chk("fault_sticky", int'(fault), 1);

    // illegal memory op3
    start_seq();
    bus.ir = 32'hC4086000;
    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    run_until("bad_op3", S_FAULT, 0, 0, 1'b0, 20, cyc);
    chk("bad_op3_latency", cyc, 3);

    // fetch wait timeout: FAULT 16 cycles after entering FWAIT
    start_seq();
    bus.ir = 32'h82004002;
    run_until("fwait_timeout", S_FAULT, 99, 99, 1'b0, 40, cyc);
    chk("fwait_timeout_cycles", cyc, 17);
    chk("fwait_timeout_fault", int'(fault), 1);

    // memory wait timeout
    start_seq();
    bus.ir = 32'hC4006000;
    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_MADDR, 0, 0, EN_MAR, 1, 0));
    run_until("mwait_timeout", S_FAULT, 0, 99, 1'b0, 40, cyc);
    chk("mwait_timeout_cycles", cyc, 20);

    // finish beats a simultaneous mfc in MWAIT
    start_seq();
    bus.ir = 32'hC4006000;
    push(mk(S_FWAIT, 1, 1, EN_IR, 0, 0));
    push(mk(S_MADDR, 0, 0, EN_MAR, 1, 0));
    run_until("finish", S_HALT, 0, 1, 1'b1, 40, cyc);
    chk("finish_cycles", cyc, 6);
    chk("halt_mov", int'(bus.mov), 0);
    chk("halt_busy", int'(busy), 0);
    chk("halt_no_fault", int'(fault), 0);
    start = 1'b1; step(); start = 1'b0; step();
    chk("halt_absorbing", int'(state), int'(S_HALT));
    rst_n = 1'b0;
    step();
    chk("halt_reset_idle", int'(state), int'(S_IDLE));
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", int'(state), int'(S_IDLE));

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
